// File: rtl/flash_arbiter_pkg.sv
// Shared types and defaults for the two-port flash word-read arbiter.
package flash_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF        = 22;
    localparam int unsigned DATA_W            = 16;
    localparam int unsigned START_TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester ports and flash reader handshake of the arbiter, bundled as one interface.
interface flash_arbiter_if
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic [DATA_W-1:0] data0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [DATA_W-1:0] data1;
    logic              flash_ready;
    logic              flash_busy;
    logic [DATA_W-1:0] flash_dout;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_cs;
    logic              err;

    // Arbiter side
    modport slave (
        input  req0, addr0, req1, addr1, flash_ready, flash_busy, flash_dout,
        output ack0, data0, ack1, data1, flash_addr, flash_cs, err
    );

    // Requesters plus reader side
    modport master (
        output req0, addr0, req1, addr1, flash_ready, flash_busy, flash_dout,
        input  ack0, data0, ack1, data1, flash_addr, flash_cs, err
    );
endinterface

// File: rtl/flash_arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port that did not win last.
module flash_arb_rr2
    import flash_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      rr_last,
    output port_t      grant_c,
    output logic       valid_c
);
    always_comb begin
        grant_c = PORT0;
        valid_c = |req;
        if (req == 2'b11) begin
            grant_c = port_t'(~rr_last);
        end else if (req[1]) begin
            grant_c = PORT1;
        end
    end
endmodule

// File: rtl/flash_arbiter.sv
// Shares one SPI flash word reader between two requesters with round-robin arbitration.
// Optional per-port one-entry read cache: define FLASH_ARBITER_CACHE_EN.
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
    input logic            clk,
    input logic            reset,
    flash_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    state_t            state, state_nxt;
    port_t             grant, grant_nxt;
    port_t             rr_last, rr_last_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              cs_q, cs_nxt;
    logic              ack0_q, ack0_nxt;
    logic              ack1_q, ack1_nxt;
    logic [DATA_W-1:0] data0_q, data0_nxt;
    logic [DATA_W-1:0] data1_q, data1_nxt;
    logic              err_q, err_nxt;

    port_t             pick_c;
    logic              pick_vld_c;
    logic [ADDR_W-1:0] pick_addr_c;
    logic              can_grant_c;
    logic              timeout_c;
    logic              cache_hit_c;
    logic [DATA_W-1:0] cache_word_c;

    flash_arb_rr2 u_rr (
        .req     ({bus.req1, bus.req0}),
        .rr_last (rr_last),
        .grant_c (pick_c),
        .valid_c (pick_vld_c)
    );

    assign pick_addr_c = (pick_c == PORT1) ? bus.addr1 : bus.addr0;
    assign can_grant_c = pick_vld_c && bus.flash_ready && !bus.flash_busy;
    assign timeout_c   = (cnt == CNT_LAST);

`ifdef FLASH_ARBITER_CACHE_EN
    logic [1:0]             c_vld;
    logic [1:0][ADDR_W-1:0] c_tag;
    logic [1:0][DATA_W-1:0] c_word;
    logic                   cache_wr_c;

    // Every flash completion refreshes the granted port's entry
    assign cache_wr_c = (state == ST_RUN) && !bus.flash_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_vld  <= '0;
            c_tag  <= '0;
            c_word <= '0;
        end else if (cache_wr_c) begin
            c_vld[grant]  <= 1'b1;
            c_tag[grant]  <= addr_q;
            c_word[grant] <= bus.flash_dout;
        end
    end

    assign cache_hit_c  = pick_vld_c && c_vld[pick_c] && (c_tag[pick_c] == pick_addr_c);
    assign cache_word_c = c_word[pick_c];
`else
    assign cache_hit_c  = 1'b0;
    assign cache_word_c = '0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant   <= PORT0;
            rr_last <= PORT1;
            cnt     <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_last <= rr_last_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_nxt;
            cs_q    <= cs_nxt;
            ack0_q  <= ack0_nxt;
            ack1_q  <= ack1_nxt;
            data0_q <= data0_nxt;
            data1_q <= data1_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cache_hit_c) begin
                    state_nxt = ST_GAP;
                end else if (can_grant_c) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bus.flash_busy) begin
                    state_nxt = ST_RUN;
                end else if (timeout_c) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_RUN: begin
                if (!bus.flash_busy) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        grant_nxt   = grant;
        rr_last_nxt = rr_last;
        cnt_nxt     = cnt;
        addr_nxt    = addr_q;
        cs_nxt      = cs_q;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        data0_nxt   = data0_q;
        data1_nxt   = data1_q;
        err_nxt     = err_q;
        case (state)
            ST_IDLE: begin
                if (cache_hit_c) begin
                    rr_last_nxt = pick_c;
                    if (pick_c == PORT1) begin
                        ack1_nxt  = 1'b1;
                        data1_nxt = cache_word_c;
                    end else begin
                        ack0_nxt  = 1'b1;
                        data0_nxt = cache_word_c;
                    end
                end else if (can_grant_c) begin
                    grant_nxt = pick_c;
                    addr_nxt  = pick_addr_c;
                    cs_nxt    = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (!bus.flash_busy) begin
                    // Reader never answered: flag it and drop cs so the request retries
                    if (timeout_c) begin
                        err_nxt = 1'b1;
                        cs_nxt  = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!bus.flash_busy) begin
                    rr_last_nxt = grant;
                    cs_nxt      = 1'b0;
                    if (grant == PORT1) begin
                        ack1_nxt  = 1'b1;
                        data1_nxt = bus.flash_dout;
                    end else begin
                        ack0_nxt  = 1'b1;
                        data0_nxt = bus.flash_dout;
                    end
                end
            end
            ST_GAP:  cs_nxt = 1'b0;
            default: cs_nxt = 1'b0;
        endcase
    end

    assign bus.flash_addr = addr_q;
    assign bus.flash_cs   = cs_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.data0      = data0_q;
    assign bus.data1      = data1_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed self-checking bench for flash_arbiter with a behavioural flash reader model.
module tb_flash_arbiter;
    import flash_arbiter_pkg::*;

    localparam int unsigned AW = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    flash_arbiter_if #(.ADDR_W(AW)) bus();

    flash_arbiter #(.ADDR_W(AW), .START_TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reader model: 2-flop cs sync, busy for 4 clocks, word = f(address)
    logic          model_dead = 1'b0;
    logic [1:0]    cs_s;
    logic [2:0]    bcnt;
    logic [AW-1:0] m_addr;

    function automatic logic [15:0] word_of(input logic [AW-1:0] a);
        return 16'hA45A ^ a[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s           <= 2'b00;
            bcnt           <= 3'd0;
            m_addr         <= '0;
            bus.flash_busy <= 1'b0;
            bus.flash_dout <= 16'h0000;
        end else begin
            cs_s <= {cs_s[0], bus.flash_cs};
            if (!bus.flash_busy && cs_s == 2'b01 && !model_dead) begin
                bus.flash_busy <= 1'b1;
                bcnt           <= 3'd3;
                m_addr         <= bus.flash_addr;
            end else if (bus.flash_busy) begin
                if (bcnt == 3'd0) begin
                    bus.flash_busy <= 1'b0;
                    bus.flash_dout <= word_of(m_addr);
                end else begin
                    bcnt <= bcnt - 3'd1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.flash_cs, bus.ack0, bus.ack1, bus.err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl: got cs/ack0/ack1/err=%b want 0000",
                     {bus.flash_cs, bus.ack0, bus.ack1, bus.err});
        end
        n_cmp++;
        if ({bus.flash_addr, bus.data0, bus.data1} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h d0=%h d1=%h want zeros",
                     bus.flash_addr, bus.data0, bus.data1);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_dual();
        int order[6];
        int n_ack = 0;
        int both = 0;
        bus.addr0 = 22'h10;
        bus.addr1 = 22'h20;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        for (int i = 0; i < 300 && n_ack < 6; i++) begin
            step();
            if (bus.ack0 && bus.ack1) both++;
            if (bus.ack0) begin
                order[n_ack] = 0;
                n_cmp++;
                if (bus.data0 !== word_of(22'h10)) begin
                    n_bad++;
                    $display("FAIL dual_data0: got %h want %h", bus.data0, word_of(22'h10));
                end
                n_ack++;
            end else if (bus.ack1) begin
                order[n_ack] = 1;
                n_cmp++;
                if (bus.data1 !== word_of(22'h20)) begin
                    n_bad++;
                    $display("FAIL dual_data1: got %h want %h", bus.data1, word_of(22'h20));
                end
                n_ack++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_cmp++;
        if (n_ack !== 6) begin
            n_bad++;
            $display("FAIL dual_count: got %0d acks want 6", n_ack);
        end
        for (int i = 0; i < n_ack; i++) begin
            n_cmp++;
            if (order[i] !== (i % 2)) begin
                n_bad++;
                $display("FAIL dual_order[%0d]: got port %0d want %0d", i, order[i], i % 2);
            end
        end
        n_cmp++;
        if (both !== 0) begin
            n_bad++;
            $display("FAIL dual_both_ack: got %0d cycles with both acks want 0", both);
        end
        repeat (4) step();
    endtask

    task automatic test_single_read();
        int acks0 = 0;
        int acks1 = 0;
        int cs_cyc = 0;
        int bad_addr = 0;
        logic [15:0] got = '0;
        bus.addr0 = 22'h000100;
        bus.req0  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.flash_cs) begin
                cs_cyc++;
                if (bus.flash_addr !== 22'h000100) bad_addr++;
            end
            if (bus.ack1) acks1++;
            if (bus.ack0) begin
                acks0++;
                got = bus.data0;
                bus.req0 = 1'b0;
            end
        end
        n_cmp++;
        if (acks0 !== 1) begin
            n_bad++;
            $display("FAIL single_ack0_count: got %0d want 1", acks0);
        end
        n_cmp++;
        if (got !== 16'hA55A) begin
            n_bad++;
            $display("FAIL single_data0: got %h want a55a", got);
        end
        n_cmp++;
        if (cs_cyc == 0 || bad_addr != 0) begin
            n_bad++;
            $display("FAIL single_flash_addr: cs cycles %0d, cycles with wrong addr %0d want >0 and 0",
                     cs_cyc, bad_addr);
        end
        n_cmp++;
        if (acks1 !== 0) begin
            n_bad++;
            $display("FAIL single_ack1: got %0d acks want 0", acks1);
        end
        n_cmp++;
        if (bus.data0 !== 16'hA55A) begin
            n_bad++;
            $display("FAIL single_data_hold: got %h want a55a", bus.data0);
        end
    endtask

    task automatic test_ready();
        int cs_cyc = 0;
        int lat = 0;
        bit got_ack = 0;
        bus.flash_ready = 1'b0;
        bus.addr1 = 22'h30;
        bus.req1  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.flash_cs) cs_cyc++;
        end
        n_cmp++;
        if (cs_cyc !== 0) begin
            n_bad++;
            $display("FAIL ready_low_cs: got %0d cs cycles want 0", cs_cyc);
        end
        bus.flash_ready = 1'b1;
        for (int i = 0; i < 5 && !bus.flash_cs; i++) begin
            step();
            lat++;
        end
        n_cmp++;
        if (!(bus.flash_cs && lat >= 1 && lat <= 2)) begin
            n_bad++;
            $display("FAIL ready_rise_cs: got cs=%b after %0d clocks want 1 within 2", bus.flash_cs, lat);
        end
        // Ready drops mid-transfer: the transfer must still complete
        bus.flash_ready = 1'b0;
        for (int i = 0; i < 40 && !got_ack; i++) begin
            step();
            if (bus.ack1) got_ack = 1;
        end
        bus.req1 = 1'b0;
        n_cmp++;
        if (!got_ack || bus.data1 !== word_of(22'h30)) begin
            n_bad++;
            $display("FAIL ready_midop: got ack=%b data1=%h want 1 %h", got_ack, bus.data1, word_of(22'h30));
        end
        step();
        bus.addr0 = 22'h77;
        bus.req0  = 1'b1;
        cs_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.flash_cs) cs_cyc++;
        end
        n_cmp++;
        if (cs_cyc !== 0) begin
            n_bad++;
            $display("FAIL ready_still_low_cs: got %0d cs cycles want 0", cs_cyc);
        end
        bus.flash_ready = 1'b1;
        got_ack = 0;
        for (int i = 0; i < 40 && !got_ack; i++) begin
            step();
            if (bus.ack0) got_ack = 1;
        end
        bus.req0 = 1'b0;
        n_cmp++;
        if (!got_ack || bus.data0 !== word_of(22'h77)) begin
            n_bad++;
            $display("FAIL ready_restore: got ack=%b data0=%h want 1 %h", got_ack, bus.data0, word_of(22'h77));
        end
        repeat (3) step();
    endtask

    task automatic test_timeout();
        int n = 0;
        bit got_ack = 0;
        model_dead = 1'b1;
        bus.addr0  = 22'h40;
        bus.req0   = 1'b1;
        for (int i = 0; i < 10 && !bus.flash_cs; i++) step();
        n_cmp++;
        if (bus.err !== 1'b0 || bus.flash_cs !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_start: got err=%b cs=%b want 0 1", bus.err, bus.flash_cs);
        end
        for (int i = 0; i < 20 && !bus.err; i++) begin
            step();
            n++;
        end
        n_cmp++;
        if (n !== 8 || bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err: got err=%b after %0d clocks want 1 after 8", bus.err, n);
        end
        n_cmp++;
        if (bus.flash_cs !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_cs_drop: got cs=%b want 0", bus.flash_cs);
        end
        model_dead = 1'b0;
        for (int i = 0; i < 60 && !got_ack; i++) begin
            step();
            if (bus.ack0) got_ack = 1;
        end
        bus.req0 = 1'b0;
        n_cmp++;
        if (!got_ack || bus.data0 !== word_of(22'h40)) begin
            n_bad++;
            $display("FAIL timeout_retry: got ack=%b data0=%h want 1 %h", got_ack, bus.data0, word_of(22'h40));
        end
        n_cmp++;
        if (bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got err=%b want 1", bus.err);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_run();
        int acks = 0;
        bit got_ack = 0;
        bus.addr0 = 22'h55;
        bus.req0  = 1'b1;
        for (int i = 0; i < 20 && !bus.flash_busy; i++) step();
        step();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.flash_cs, bus.ack0, bus.ack1, bus.err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_run_ctl: got cs/ack0/ack1/err=%b want 0000",
                     {bus.flash_cs, bus.ack0, bus.ack1, bus.err});
        end
        n_cmp++;
        if ({bus.flash_addr, bus.data0, bus.data1} !== '0) begin
            n_bad++;
            $display("FAIL rst_run_data: got addr=%h d0=%h d1=%h want zeros",
                     bus.flash_addr, bus.data0, bus.data1);
        end
        bus.req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.ack0 || bus.ack1) acks++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.ack0 || bus.ack1) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL rst_run_no_ack: got %0d acks want 0", acks);
        end
        bus.addr0 = 22'h66;
        bus.req0  = 1'b1;
        for (int i = 0; i < 40 && !got_ack; i++) begin
            step();
            if (bus.ack0) got_ack = 1;
        end
        bus.req0 = 1'b0;
        n_cmp++;
        if (!got_ack || bus.data0 !== word_of(22'h66)) begin
            n_bad++;
            $display("FAIL rst_run_after: got ack=%b data0=%h want 1 %h", got_ack, bus.data0, word_of(22'h66));
        end
        repeat (3) step();
    endtask

`ifdef FLASH_ARBITER_CACHE_EN
    task automatic test_cache();
        int cs_cyc = 0;
        int lat = 0;
        bit got_ack = 0;
        bus.addr0 = 22'h3FF;
        bus.req0  = 1'b1;
        for (int i = 0; i < 40 && !got_ack; i++) begin
            step();
            if (bus.ack0) got_ack = 1;
        end
        bus.req0 = 1'b0;
        repeat (3) step();
        got_ack  = 0;
        bus.req0 = 1'b1;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            step();
            lat++;
            if (bus.flash_cs) cs_cyc++;
            if (bus.ack0) got_ack = 1;
        end
        bus.req0 = 1'b0;
        n_cmp++;
        if (!got_ack || lat > 2 || cs_cyc !== 0) begin
            n_bad++;
            $display("FAIL cache_hit: got ack=%b lat=%0d cs=%0d want 1 <=2 0", got_ack, lat, cs_cyc);
        end
        n_cmp++;
        if (bus.data0 !== word_of(22'h3FF)) begin
            n_bad++;
            $display("FAIL cache_hit_data: got %h want %h", bus.data0, word_of(22'h3FF));
        end
        repeat (3) step();
        got_ack   = 0;
        cs_cyc    = 0;
        bus.addr0 = 22'h3FE;
        bus.req0  = 1'b1;
        for (int i = 0; i < 40 && !got_ack; i++) begin
            step();
            if (bus.flash_cs) cs_cyc++;
            if (bus.ack0) got_ack = 1;
        end
        bus.req0 = 1'b0;
        n_cmp++;
        if (!got_ack || cs_cyc == 0 || bus.data0 !== word_of(22'h3FE)) begin
            n_bad++;
            $display("FAIL cache_miss: got ack=%b cs=%0d data0=%h want 1 >0 %h",
                     got_ack, cs_cyc, bus.data0, word_of(22'h3FE));
        end
        repeat (3) step();
    endtask
`endif

    initial begin
        bus.req0        = 1'b0;
        bus.req1        = 1'b0;
        bus.addr0       = '0;
        bus.addr1       = '0;
        bus.flash_ready = 1'b1;
        test_reset();
        test_dual();
        test_single_read();
        test_ready();
        test_timeout();
        test_reset_mid_run();
`ifdef FLASH_ARBITER_CACHE_EN
        test_cache();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
